fp_minmax_reduce_d: RTL
=======================

# fp_minmax_reduce_d

Streaming double-precision min/max reduction stage that feeds the combinational `fp_minmax_d` comparator. It accepts a packetised stream of IEEE-754 binary64 elements over a valid/ready handshake and folds each element into a running accumulator. When the packet ends, it emits one result word together with an invalid-operation (NV) flag and an element count. It sits between the vector/loop issue logic and FP writeback, and produces the fflags NV bit that the combinational comparator does not generate.

## Interface
- `CNT_W`, default 16: width of the element counter.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `in_valid` in 1: element valid.
- `in_ready` out 1: stage can accept an element.
- `in_data` in 64: binary64 element.
- `in_last` in 1: element is the last in its packet.
- `in_op` in 1: 0 = min, 1 = max; sampled only on a packet's first element.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_data` out 64: reduction result.
- `out_nv` out 1: set if any packet element was a signalling NaN.
- `out_count` out CNT_W: number of elements in the packet, saturating at all-ones.

## Operation
- FSM states are IDLE, ACCUM and DONE. Reset state is IDLE.
- **IDLE**
  - `in_ready`=1.
  - On accept: load acc ← `in_data`; a NaN input is stored as canonical NaN 0x7FF8000000000000.
  - Latch op ← `in_op`, count ← 1, nv ← is_snan(`in_data`).
  - Go to DONE if `in_last`, else go to ACCUM.
- **ACCUM**
  - `in_ready`=1.
  - On accept: acc ← `fp_minmax_d`(acc, `in_data`, op), count ← sat(count+1), nv ← nv | is_snan(`in_data`).
  - Go to DONE if `in_last`.
  - `in_op` is ignored in this state.
- **DONE**
  - `in_ready`=0, `out_valid`=1.
  - `out_data`/`out_nv`/`out_count` come from registers and hold stable while `out_ready`=0.
  - On `out_ready`=1: go to IDLE.
- **Combine rules** (inherited from the comparator):
  - Both operands NaN → canonical NaN.
  - One operand NaN → the other operand.
  - ±0 pair → min gives 0x8000000000000000, max gives 0x0000000000000000.
  - Otherwise sign/exponent/fraction ordering.
- **Classification**
  - is_nan = exp==0x7FF && frac!=0.
  - is_snan = is_nan && frac[51]==0.
  - A quiet NaN does not set nv.
- **Counter**: saturates at 2^CNT_W−1 and does not wrap.
- **Reset mid-operation**: immediately returns to IDLE and clears acc, count, nv and op. No partial result is emitted.

## Timing
- Reset values: `in_ready`=0 while `rst_n`=0 and 1 in IDLE afterwards; `out_valid`=0; `out_data`=0; `out_nv`=0; `out_count`=0.
- Throughput is one element per cycle in IDLE/ACCUM. `in_valid` gaps are allowed and cause no state change.
- Latency: `out_valid` rises on the clock edge that accepts the `in_last` element, so it is visible the next cycle.
- There is at least one cycle in DONE between packets, because `in_ready`=0 while `out_valid`=1.
- An element is accepted only when `in_valid`&&`in_ready` at the clock edge.
- Once `out_valid` is asserted, it stays high until `out_ready`.
- All outputs are driven from registers or the state decode. There is no combinational path from `in_*` to `out_*`.
- The `fp_minmax_d` path (acc → compare → acc) must close in one cycle.

## Structure
- Shared package `fp_d_pkg`:
  - `CANON_NAN_D` = 64'h7FF8000000000000.
  - `EXP_MAX_D` = 11'h7FF.
  - Functions `is_nan_d` and `is_snan_d`.
  - State enum `reduce_state_t` {IDLE, ACCUM, DONE}.
- The one sub-module is `fp_minmax_d`, instantiated with operands (acc, `in_data`) and the latched op. No other hierarchy.

## Test plan
1. Max packet {0x3FF0000000000000, 0xC000000000000000, 0x400C000000000000 (last)} → `out_data`=0x400C000000000000, `out_count`=3, `out_nv`=0; `out_valid` appears one cycle after the third accept.
2. Zero signs: min {0x0000000000000000, 0x8000000000000000} → 0x8000000000000000; max of the same pair → 0x0000000000000000.
3. NaN handling:
   - Min {0x7FF8000000000000, 0x4000000000000000} → 0x4000000000000000, nv=0.
   - {0x7FF0000000000001, 0x7FF0000000000002} → 0x7FF8000000000000, nv=1.
4. Single-element packet 0x4014000000000000 with `in_last`, and `out_ready` held low for 3 cycles → output held stable with count=1 and `in_ready`=0; it releases on `out_ready`, then IDLE accepts a new element the next cycle.
5. Reset mid-stream: assert `rst_n`=0 after 2 elements of a 4-element packet → all outputs go to 0 immediately. A following packet {0xBFF0000000000000 (last)}, op=min, yields 0xBFF0000000000000 with count=1.
6. `in_valid` gaps plus an `in_op` toggle mid-packet → the result follows the op latched on the first element; count excludes idle cycles.

Source files
------------

// File: rtl/fp_d_pkg.sv
// Shared binary64 constants, NaN classification helpers and the reduction FSM state type.
package fp_d_pkg;

    localparam logic [63:0] CANON_NAN_D = 64'h7FF8000000000000;
    localparam logic [10:0] EXP_MAX_D   = 11'h7FF;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } reduce_state_t;

    function automatic logic is_nan_d(input logic [63:0] x);
        return (x[62:52] == EXP_MAX_D) && (x[51:0] != 52'd0);
    endfunction

    // Signalling NaNs have the quiet bit (fraction MSB) clear.
    function automatic logic is_snan_d(input logic [63:0] x);
        return is_nan_d(x) && !x[51];
    endfunction

endpackage

// File: rtl/fp_minmax_d.sv
// Combinational binary64 min/max: NaN-suppressing, -0 < +0, canonical NaN when both are NaN.
module fp_minmax_d
    import fp_d_pkg::*;
(
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic        max_i,
    output logic [63:0] res_o
);

    logic a_nan;
    logic b_nan;
    logic both_zero;
    logic a_lt_b;

    assign a_nan     = is_nan_d(a_i);
    assign b_nan     = is_nan_d(b_i);
    assign both_zero = (a_i[62:0] == 63'd0) && (b_i[62:0] == 63'd0);

    // Sign-magnitude ordering: magnitudes compare inverted when both are negative.
    always_comb begin
        a_lt_b = 1'b0;
        if (a_i[63] != b_i[63]) begin
            a_lt_b = a_i[63];
        end else if (!a_i[63]) begin
            a_lt_b = a_i[62:0] < b_i[62:0];
        end else begin
            a_lt_b = a_i[62:0] > b_i[62:0];
        end
    end

    always_comb begin
        res_o = b_i;
        if (a_nan && b_nan) begin
            res_o = CANON_NAN_D;
        end else if (a_nan) begin
            res_o = b_i;
        end else if (b_nan) begin
            res_o = a_i;
        end else if (both_zero) begin
            res_o = max_i ? 64'h0000000000000000 : 64'h8000000000000000;
        end else begin
            res_o = (a_lt_b ^ max_i) ? a_i : b_i;
        end
    end

endmodule

// File: rtl/fp_minmax_reduce_d.sv
// Streaming binary64 min/max reduction: folds a packet into one result with NV flag and count.
module fp_minmax_reduce_d
    import fp_d_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    input  logic             in_last,
    input  logic             in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             out_nv,
    output logic [CNT_W-1:0] out_count
);

    reduce_state_t    state_q;
    logic [63:0]      acc_q;
    logic             op_q;
    logic             nv_q;
    logic             rdy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [63:0]      cmp_res;
    logic             accept;

    assign accept = in_valid && rdy_q;

    fp_minmax_d u_cmp (
        .a_i   (acc_q),
        .b_i   (in_data),
        .max_i (op_q),
        .res_o (cmp_res)
    );

    // Ready is registered so it stays low while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= 64'd0;
            op_q    <= 1'b0;
            nv_q    <= 1'b0;
            rdy_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    rdy_q <= !(accept && in_last);
                    if (accept) begin
                        acc_q   <= is_nan_d(in_data) ? CANON_NAN_D : in_data;
                        op_q    <= in_op;
                        cnt_q   <= CNT_W'(1);
                        nv_q    <= is_snan_d(in_data);
                        state_q <= in_last ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    rdy_q <= !(accept && in_last);
                    if (accept) begin
                        acc_q <= cmp_res;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        nv_q <= nv_q | is_snan_d(in_data);
                        if (in_last) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    rdy_q <= out_ready;
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = (state_q == DONE);
    assign out_data  = acc_q;
    assign out_nv    = nv_q;
    assign out_count = cnt_q;

endmodule
